// File: rtl/xgmac_cfg_pkg.sv
// Shared types and constants for the 10G MAC management-bus sequencer.
package xgmac_cfg_pkg;

    typedef enum logic [2:0] {
        S_WAIT_RST,
        S_WR,
        S_LOCK,
        S_RUN,
        S_IRQ,
        S_ERR
    } state_e;

    localparam logic [31:0] ADDR_RX_CFG = 32'h0000_0404;
    localparam logic [31:0] ADDR_TX_CFG = 32'h0000_0408;
    localparam logic [31:0] ADDR_FC_CFG = 32'h0000_040C;

    localparam int unsigned NUM_STEPS = 3;
    localparam logic [1:0]  LAST_STEP = 2'(NUM_STEPS - 1);

    // Configuration order: flow control, then transmitter, then receiver.
    function automatic logic [31:0] step_addr(input logic [1:0] k);
        case (k)
            2'd0:    step_addr = ADDR_FC_CFG;
            2'd1:    step_addr = ADDR_TX_CFG;
            default: step_addr = ADDR_RX_CFG;
        endcase
    endfunction

endpackage

// File: rtl/xgmac_sync2.sv
// Two-flop synchronizer for single-bit level signals entering the bus clock domain.
module xgmac_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/xgmac_cfg_seq.sv
// Management-bus sequencer: configures the MAC after reset, gates the AXI-Stream
// datapath on PCS block lock and reads the interrupt status word on each interrupt.
module xgmac_cfg_seq
    import xgmac_cfg_pkg::*;
#(
    parameter logic [31:0] C_FC_CFG   = 32'h0000_0000,
    parameter logic [31:0] C_TX_CFG   = 32'h1000_0000,
    parameter logic [31:0] C_RX_CFG   = 32'h1000_0000,
    parameter logic [31:0] C_INT_ADDR = 32'h0000_0600,
    parameter int unsigned C_TIMEOUT  = 1023
) (
    input  logic        bus2ip_clk,
    input  logic        bus2ip_resetn,
    input  logic        resetdone,
    input  logic [7:0]  core_status,
    input  logic        xgmacint,
    output logic        bus2ip_cs,
    output logic        bus2ip_rnw,
    output logic [31:0] bus2ip_addr,
    output logic [31:0] bus2ip_data,
    input  logic [31:0] ip2bus_data,
    input  logic        ip2bus_rdack,
    input  logic        ip2bus_wrack,
    input  logic        ip2bus_error,
    output logic        tx_axis_aresetn,
    output logic        rx_axis_aresetn,
    output logic        cfg_done,
    output logic        cfg_error,
    output logic [31:0] irq_status
);

    localparam logic [9:0] TMO = 10'(C_TIMEOUT);

    function automatic logic [31:0] step_data(input logic [1:0] k);
        case (k)
            2'd0:    step_data = C_FC_CFG;
            2'd1:    step_data = C_TX_CFG;
            default: step_data = C_RX_CFG;
        endcase
    endfunction

    logic rstdone_s, lock_s, int_s;
    logic unused_core_status;

    assign unused_core_status = ^core_status[7:1];

    xgmac_sync2 u_sync_rstdone (
        .clk_i  (bus2ip_clk),
        .rst_ni (bus2ip_resetn),
        .d_i    (resetdone),
        .q_o    (rstdone_s)
    );

    xgmac_sync2 u_sync_lock (
        .clk_i  (bus2ip_clk),
        .rst_ni (bus2ip_resetn),
        .d_i    (core_status[0]),
        .q_o    (lock_s)
    );

    xgmac_sync2 u_sync_int (
        .clk_i  (bus2ip_clk),
        .rst_ni (bus2ip_resetn),
        .d_i    (xgmacint),
        .q_o    (int_s)
    );

    state_e      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic        cs_q, cs_d;
    logic        rnw_q, rnw_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        aresetn_q, aresetn_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] irq_q, irq_d;
    logic        pend_q, pend_d;
    logic        int_prev_q;

    logic ack_ok, timeout, int_rise, irq_capture;

    // Only an acknowledge of the same type as the outstanding request counts.
    assign ack_ok      = cs_q & (rnw_q ? ip2bus_rdack : ip2bus_wrack);
    assign timeout     = cs_q & ~ack_ok & (cnt_q == TMO);
    assign int_rise    = int_s & ~int_prev_q;
    assign irq_capture = (state_q == S_LOCK) | (state_q == S_RUN) | (state_q == S_IRQ);

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        cs_d      = cs_q;
        rnw_d     = rnw_q;
        addr_d    = addr_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        aresetn_d = aresetn_q;
        done_d    = done_q;
        err_d     = err_q;
        irq_d     = irq_q;
        pend_d    = pend_q | (int_rise & irq_capture);

        if (cs_q && !ack_ok) begin
            cnt_d = cnt_q + 10'd1;
        end

        case (state_q)
            S_WAIT_RST: begin
                if (rstdone_s) begin
                    state_d = S_WR;
                    cs_d    = 1'b1;
                    rnw_d   = 1'b0;
                    addr_d  = step_addr(step_q);
                    data_d  = step_data(step_q);
                    cnt_d   = '0;
                end
            end
            S_WR: begin
                if (cs_q) begin
                    if (ack_ok) begin
                        cs_d = 1'b0;
                        if (ip2bus_error) begin
                            state_d = S_ERR;
                        end else if (step_q == LAST_STEP) begin
                            state_d = S_LOCK;
                        end else begin
                            step_d = step_q + 2'd1;
                        end
                    end else if (timeout) begin
                        state_d = S_ERR;
                    end
                end else begin
                    // The idle cycle after an ack falls here; issue the next step.
                    cs_d   = 1'b1;
                    rnw_d  = 1'b0;
                    addr_d = step_addr(step_q);
                    data_d = step_data(step_q);
                    cnt_d  = '0;
                end
            end
            S_LOCK: begin
                if (lock_s) begin
                    aresetn_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    aresetn_d = 1'b0;
                    done_d    = 1'b0;
                    state_d   = S_LOCK;
                end else if (pend_q) begin
                    cs_d    = 1'b1;
                    rnw_d   = 1'b1;
                    addr_d  = C_INT_ADDR;
                    data_d  = '0;
                    cnt_d   = '0;
                    pend_d  = int_rise;
                    state_d = S_IRQ;
                end
            end
            S_IRQ: begin
                if (ack_ok) begin
                    cs_d = 1'b0;
                    if (ip2bus_error) begin
                        state_d = S_ERR;
                    end else begin
                        irq_d = ip2bus_data;
                        // Lock loss seen during the read is acted on as the read retires.
                        if (!lock_s) begin
                            aresetn_d = 1'b0;
                            done_d    = 1'b0;
                            state_d   = S_LOCK;
                        end else begin
                            state_d = S_RUN;
                        end
                    end
                end else if (timeout) begin
                    state_d = S_ERR;
                end
            end
            default: begin
                state_d = S_ERR;
            end
        endcase

        if (state_d == S_ERR) begin
            cs_d      = 1'b0;
            aresetn_d = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b1;
        end
    end

    always_ff @(posedge bus2ip_clk or negedge bus2ip_resetn) begin
        if (!bus2ip_resetn) begin
            state_q    <= S_WAIT_RST;
            step_q     <= '0;
            cs_q       <= 1'b0;
            rnw_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            aresetn_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            irq_q      <= '0;
            pend_q     <= 1'b0;
            int_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            cs_q       <= cs_d;
            rnw_q      <= rnw_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            aresetn_q  <= aresetn_d;
            done_q     <= done_d;
            err_q      <= err_d;
            irq_q      <= irq_d;
            pend_q     <= pend_d;
            int_prev_q <= int_s;
        end
    end

    assign bus2ip_cs       = cs_q;
    assign bus2ip_rnw      = rnw_q;
    assign bus2ip_addr     = addr_q;
    assign bus2ip_data     = data_q;
    assign tx_axis_aresetn = aresetn_q;
    assign rx_axis_aresetn = aresetn_q;
    assign cfg_done        = done_q;
    assign cfg_error       = err_q;
    assign irq_status      = irq_q;

endmodule

// File: tb/tb_xgmac_cfg_seq.sv
// Directed bench for xgmac_cfg_seq with a randomized bus responder and a
// transaction-level reference of the expected register accesses.
module tb_xgmac_cfg_seq;

    localparam logic [31:0] FC_CFG   = 32'h0000_0000;
    localparam logic [31:0] TX_CFG   = 32'h1000_0000;
    localparam logic [31:0] RX_CFG   = 32'h1000_0000;
    localparam logic [31:0] INT_ADDR = 32'h0000_0600;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        resetdone = 1'b0;
    logic [7:0]  core_status = 8'h00;
    logic        xgmacint = 1'b0;
    logic        cs, rnw;
    logic [31:0] addr, wdata;
    logic [31:0] rdata = 32'h0;
    logic        rdack = 1'b0, wrack = 1'b0, berr = 1'b0;
    logic        txn, rxn, done, cerr;
    logic [31:0] irq;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    xgmac_cfg_seq dut (
        .bus2ip_clk      (clk),
        .bus2ip_resetn   (rst_n),
        .resetdone       (resetdone),
        .core_status     (core_status),
        .xgmacint        (xgmacint),
        .bus2ip_cs       (cs),
        .bus2ip_rnw      (rnw),
        .bus2ip_addr     (addr),
        .bus2ip_data     (wdata),
        .ip2bus_data     (rdata),
        .ip2bus_rdack    (rdack),
        .ip2bus_wrack    (wrack),
        .ip2bus_error    (berr),
        .tx_axis_aresetn (txn),
        .rx_axis_aresetn (rxn),
        .cfg_done        (done),
        .cfg_error       (cerr),
        .irq_status      (irq)
    );

    typedef struct {
        logic [31:0] addr;
        logic        rnw;
        logic [31:0] data;
        int unsigned cyc;
    } txn_t;

    txn_t        log_q[$];
    txn_t        exp_cfg[3];
    int          total = 0;
    int          bad = 0;

    int          wr_delay = 2;
    int          rd_delay = 2;
    bit          rand_delay = 1'b0;
    bit          inject_wrong = 1'b0;
    int          no_ack_idx = -1;
    int          err_idx = -1;
    logic [31:0] rd_word = 32'h0;
    int unsigned ack_cyc = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus slave: logs every transaction, checks request stability, acks after a delay
    // and optionally sprinkles acks of the wrong type that must be ignored.
    initial begin : responder
        bit seen;
        int cnt;
        int cur;
        int idx;
        seen = 1'b0;
        cnt  = 0;
        cur  = 0;
        idx  = 0;
        forever begin
            @(posedge clk);
            #1;
            wrack = 1'b0;
            rdack = 1'b0;
            berr  = 1'b0;
            if (!cs) begin
                seen = 1'b0;
                continue;
            end
            if (!seen) begin
                seen = 1'b1;
                cnt  = 0;
                cur  = rand_delay ? int'($urandom_range(0, 5)) : (rnw ? rd_delay : wr_delay);
                log_q.push_back('{addr, rnw, wdata, cyc});
                idx = log_q.size() - 1;
            end else begin
                cnt++;
                chk("bus_stable", {31'h0, rnw, addr, wdata},
                    {31'h0, log_q[idx].rnw, log_q[idx].addr, log_q[idx].data});
            end
            if (idx == no_ack_idx) continue;
            if (cnt == cur) begin
                if (rnw) begin
                    rdack = 1'b1;
                    rdata = rd_word;
                end else begin
                    wrack = 1'b1;
                end
                berr    = (idx == err_idx);
                ack_cyc = cyc;
            end else if (inject_wrong && $urandom_range(0, 3) == 0) begin
                if (rnw) begin
                    wrack = 1'b1;
                end else begin
                    rdack = 1'b1;
                    rdata = $urandom;
                end
                berr = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_log(input int n, input int bound);
        int k;
        k = 0;
        while (log_q.size() < n && k < bound) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic pulse_int(input int len);
        xgmacint = 1'b1;
        cycles(len);
        xgmacint = 1'b0;
    endtask

    task automatic wait_cs_low(input int bound);
        int k;
        k = 0;
        while (cs && k < bound) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        resetdone    = 1'b0;
        core_status  = 8'h00;
        xgmacint     = 1'b0;
        wr_delay     = 2;
        rd_delay     = 2;
        rand_delay   = 1'b0;
        inject_wrong = 1'b0;
        no_ack_idx   = -1;
        err_idx      = -1;
        cycles(3);
        log_q.delete();
        rst_n = 1'b1;
    endtask

    initial begin : main
        int unsigned t0, r, t, fall, n;
        int k;
        logic [31:0] exp_irq;

        exp_cfg[0] = '{32'h40C, 1'b0, FC_CFG, 0};
        exp_cfg[1] = '{32'h408, 1'b0, TX_CFG, 0};
        exp_cfg[2] = '{32'h404, 1'b0, RX_CFG, 0};
        exp_irq    = 32'h0;

        // Reset values
        @(negedge clk);
        cycles(2);
        chk("reset_outputs", {cs, rnw, txn, rxn, done, cerr, irq, addr, wdata}, '0);
        apply_reset();

        // Nominal bring-up: resetdone at cycle 10, lock at cycle 60
        t0 = cyc;
        core_status = 8'hFE;
        cycles(10);
        r = cyc;
        resetdone = 1'b1;
        wait_log(3, 60);
        chk("cfg_write_count", log_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < log_q.size()) begin
                chk($sformatf("cfg_write_%0d", i),
                    {31'h0, log_q[i].rnw, log_q[i].addr, log_q[i].data},
                    {31'h0, exp_cfg[i].rnw, exp_cfg[i].addr, exp_cfg[i].data});
            end
        end
        if (log_q.size() >= 2) begin
            chk("first_cs_latency", log_q[0].cyc - r, 3);
            chk("write_spacing", log_q[1].cyc - log_q[0].cyc, wr_delay + 2);
        end
        while (cyc < t0 + 60) @(negedge clk);
        chk("gated_before_lock", {txn, rxn, done, cerr}, 4'b0000);
        core_status = 8'h01;
        cycles(2);
        chk("lock_not_yet", {txn, rxn, done}, 3'b000);
        cycles(1);
        chk("lock_release", {txn, rxn, done}, 3'b111);
        cycles(5);
        chk("no_extra_writes", log_q.size(), 3);

        // Interrupt reads with random data, delays and stray wrong-type acks
        inject_wrong = 1'b1;
        rand_delay   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_word = (i == 0) ? 32'hDEAD_0001 : $urandom;
            n = log_q.size();
            pulse_int(int'($urandom_range(1, 3)));
            wait_log(n + 1, 30);
            chk("irq_read_seen", log_q.size(), n + 1);
            if (log_q.size() > n) begin
                chk("irq_read_req", {log_q[n].rnw, log_q[n].addr}, {1'b1, INT_ADDR});
            end
            chk("irq_status_held", irq, exp_irq);
            wait_cs_low(20);
            exp_irq = rd_word;
            chk("irq_status", irq, exp_irq);
            chk("irq_datapath_up", {txn, rxn, done}, 3'b111);
            cycles(3);
        end
        cycles(10);
        chk("one_read_per_edge", log_q.size(), 7);

        // Plain lock loss, with an interrupt edge pending until relock
        inject_wrong = 1'b0;
        rand_delay   = 1'b0;
        core_status  = 8'h00;
        cycles(2);
        chk("lockloss_not_yet", {txn, rxn, done}, 3'b111);
        cycles(1);
        chk("lockloss_gate", {txn, rxn, done}, 3'b000);
        n = log_q.size();
        pulse_int(2);
        cycles(6);
        chk("no_read_unlocked", log_q.size(), n);
        rd_word = $urandom;
        core_status = 8'h01;
        wait_log(n + 1, 20);
        chk("pending_irq_serviced", log_q.size(), n + 1);
        if (log_q.size() > n) begin
            chk("pending_irq_req", {log_q[n].rnw, log_q[n].addr}, {1'b1, INT_ADDR});
        end
        wait_cs_low(20);
        exp_irq = rd_word;
        chk("pending_irq_status", irq, exp_irq);
        chk("relock_up", {txn, rxn, done}, 3'b111);
        cycles(3);

        // Lock loss while the interrupt read is outstanding
        rd_delay = 10;
        rd_word  = $urandom;
        n = log_q.size();
        pulse_int(1);
        wait_log(n + 1, 30);
        core_status = 8'h00;
        k = 0;
        while (txn && k < 40) begin
            @(negedge clk);
            k++;
        end
        fall = cyc;
        exp_irq = rd_word;
        chk("read_done_before_gate", irq, exp_irq);
        chk("gate_cycle_after_rdack", fall, ack_cyc + 1);
        chk("gate_all", {txn, rxn, done, cs}, 4'b0000);
        core_status = 8'h01;
        cycles(2);
        chk("relock_not_yet", {txn, rxn, done}, 3'b000);
        cycles(1);
        chk("relock_release", {txn, rxn, done}, 3'b111);
        cycles(10);
        chk("relock_no_writes", log_q.size(), n + 1);

        // Timeout on step 1 (lock held present throughout)
        apply_reset();
        core_status = 8'h01;
        no_ack_idx  = 1;
        resetdone   = 1'b1;
        wait_log(2, 40);
        chk("timeout_step1_seen", log_q.size(), 2);
        t = (log_q.size() >= 2) ? log_q[1].cyc : cyc;
        k = 0;
        while (!cerr && k < 1100) begin
            @(negedge clk);
            k++;
        end
        // Counter is 0 in the first request cycle and equals C_TIMEOUT 1023 cycles later;
        // the error state is visible one cycle after that.
        chk("timeout_cycle", cyc - t, 1024);
        chk("timeout_outputs", {cerr, cs, txn, rxn, done}, 5'b10000);
        cycles(20);
        chk("timeout_quiet", {log_q.size(), cs, txn, rxn}, {32'd2, 3'b000});

        // Bus error on step 0
        apply_reset();
        core_status = 8'h01;
        err_idx     = 0;
        resetdone   = 1'b1;
        cycles(30);
        chk("buserr_outputs", {cerr, cs, txn, rxn, done}, 5'b10000);
        chk("buserr_no_more_txn", log_q.size(), 1);

        // Reset in the middle of step 2
        apply_reset();
        wr_delay  = 6;
        resetdone = 1'b1;
        wait_log(3, 60);
        cycles(2);
        chk("step2_in_flight", {cs, addr}, {1'b1, 32'h404});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_cs_drop", cs, 1'b0);
        cycles(2);
        log_q.delete();
        r = cyc;
        rst_n = 1'b1;
        wait_log(1, 20);
        chk("restart_seen", log_q.size(), 1);
        if (log_q.size() >= 1) begin
            chk("restart_addr", {log_q[0].rnw, log_q[0].addr, log_q[0].data}, {1'b0, 32'h40C, FC_CFG});
            chk("restart_latency", log_q[0].cyc - r, 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xgmac_cfg_seq.md
# xgmac_cfg_seq

Management-bus sequencer for the 10G MAC/PHY core. It drives the core's bus2ip/ip2bus register interface in place of a bench-side bus driver. After reset it waits for transceiver reset completion, writes the MAC configuration words, and waits for PCS block lock. It then releases the AXI-Stream resets of the TX/RX datapath. While running, it services the core interrupt and re-gates the datapath on loss of lock.

## Interface
Parameters:
- C_FC_CFG, 32'h0000_0000, flow-control word written to 0x40C
- C_TX_CFG, 32'h1000_0000, transmitter config word written to 0x408 (bit28 = TX enable)
- C_RX_CFG, 32'h1000_0000, receiver config word written to 0x404 (bit28 = RX enable)
- C_INT_ADDR, 32'h0000_0600, interrupt status register read on xgmacint
- C_TIMEOUT, 1023, cycles without ack before a transaction is declared failed (10-bit counter)

Ports:
- bus2ip_clk  in  1  sole clock
- bus2ip_resetn  in  1  asynchronous, active-low reset
- resetdone  in  1  core reset complete; asynchronous, 2-flop synchronized internally
- core_status  in  8  bit0 = PCS block lock; bit0 only used, 2-flop synchronized
- xgmacint  in  1  core interrupt, level; 2-flop synchronized, rising edge detected
- bus2ip_cs  out  1  transaction request
- bus2ip_rnw  out  1  1 = read, 0 = write
- bus2ip_addr  out  32  register address
- bus2ip_data  out  32  write data
- ip2bus_data  in  32  read data, valid with ip2bus_rdack
- ip2bus_rdack / ip2bus_wrack  in  1  single-cycle acknowledge
- ip2bus_error  in  1  qualifies the acknowledge in the same cycle
- tx_axis_aresetn / rx_axis_aresetn  out  1  datapath resets (0 = held in reset)
- cfg_done  out  1  configuration complete and lock present
- cfg_error  out  1  sticky failure flag
- irq_status  out  32  last interrupt status word read

## Operation
Reset values:
- All outputs are 0, so both aresetn outputs are asserted (datapath held in reset).
- Step index is 0.

States:
- WAIT_RST: remain until synchronized resetdone = 1, then go to WR.
- WR: issue write (addr, data) for step k. Step 0 is 0x40C/C_FC_CFG, step 1 is 0x408/C_TX_CFG, step 2 is 0x404/C_RX_CFG. After the ack of step 2, go to LOCK; otherwise increment k.
- LOCK: wait for synchronized lock = 1, then release both aresetn outputs and set cfg_done = 1. Go to RUN.
- RUN:
  - On lock = 0, assert both aresetn outputs low, clear cfg_done, and go to LOCK. Configuration is not rewritten.
  - On a detected xgmacint rising edge, issue a read of C_INT_ADDR and latch ip2bus_data into irq_status on rdack. Then return to RUN.
- ERR: reached on timeout, or on an ack with ip2bus_error = 1. Sets cfg_error = 1, drops bus2ip_cs, and holds both aresetn outputs asserted low. Only bus2ip_resetn exits ERR.

Bus rules:
- bus2ip_cs, rnw, addr and data are registered and held stable from assertion until the ack cycle.
- bus2ip_cs deasserts on the cycle after the ack is sampled. There is at least one idle cycle between transactions.
- An ack whose type does not match rnw is ignored.
- Simultaneous events in RUN:
  - Lock loss takes priority over a pending interrupt. The interrupt edge stays pending in a 1-bit flag and is serviced on the next return to RUN.
  - A read already in flight completes before lock loss is acted on.
- The timeout counter clears at each transaction start. ERR is entered when the counter equals C_TIMEOUT with no ack.

## Timing
- resetdone to first bus2ip_cs: 3 cycles (2 synchronizer cycles + 1 registered state).
- Write occupancy: cs rises at t, ack at t+n, cs falls at t+n+1, next cs rises at t+n+2.
- Lock at the synchronizer input to aresetn release: 3 cycles.
- Loss of lock to aresetn low: 3 cycles, or the in-flight read completion + 1, whichever is later.
- irq_status updates on the cycle after rdack.
- Reset mid-transaction: bus2ip_cs drops immediately (asynchronously). The sequence restarts from WAIT_RST at step 0.

## Structure
- A package xgmac_cfg_pkg holds:
  - the state enumeration;
  - register address constants 0x404/0x408/0x40C;
  - the step-count constant (3).
- One sub-module, xgmac_sync2: a 2-flop synchronizer, instantiated for resetdone, lock and xgmacint.
- The remaining logic is the FSM and the transaction/timeout counter, estimated at roughly 250 lines.

## Test plan
- Nominal bring-up:
  - Stimulus: resetdone = 1 at cycle 10; wrack 2 cycles after each cs; lock at cycle 60.
  - Required: writes to 0x40C = 0, 0x408 = 0x10000000, 0x404 = 0x10000000 in that order; aresetn outputs and cfg_done go high 3 cycles after lock.
- Timeout:
  - Stimulus: never assert wrack on step 1.
  - Required: after 1023 cycles, cfg_error = 1, cs = 0, aresetn outputs stay 0.
- Bus error:
  - Stimulus: wrack with ip2bus_error = 1 on step 0.
  - Required: ERR entered, no further transactions.
- Interrupt:
  - Stimulus: xgmacint pulse in RUN; rdack with data 0xDEAD0001.
  - Required: read of 0x600 observed; irq_status = 0xDEAD0001.
- Lock loss during interrupt read:
  - Stimulus: lock drops while the read is outstanding.
  - Required: the read completes; aresetn outputs fall the cycle after; relock re-releases them with no config writes.
- Mid-transaction reset:
  - Stimulus: bus2ip_resetn low during step 2.
  - Required: cs = 0 immediately; after release, the sequence restarts at 0x40C.
